demux1to8_deser: RTL

Serial-to-parallel 1-to-8 time-division demultiplexer: the receiving end of the 8-to-1 mux datapath. Bit slot k of a frame carries mux input I[k], sent while the mux select equals k. The block steers each arriving bit into slot k under an internal 3-bit slot counter. On the 8th bit it publishes the reassembled 8-bit word through a valid/ready output register, double-buffered behind a shadow register.

---
 rtl/demux1to8_deser_pkg.sv | 17 +
 rtl/demux1to8_deser_dec3to8.sv | 19 +
 rtl/demux1to8_deser.sv | 105 ++++++++++
 3 files changed

// File: rtl/demux1to8_deser_pkg.sv
// Shared constants and types for the 1-to-8 serial-to-parallel demultiplexer.
package demux1to8_deser_pkg;

  localparam int N_SLOTS = 8;
  localparam int SLOT_W  = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t FIRST_SLOT = 3'd0;
  localparam slot_t LAST_SLOT  = 3'd7;

  // Slot index that follows idx; 7 wraps to 0 through the natural 3-bit overflow.
  function automatic slot_t next_slot(input slot_t idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/demux1to8_deser_dec3to8.sv
// 3-to-8 one-hot decoder with enable: turns the active slot index into the
// shadow-register write enables (the structural mirror of the 8-to-1 mux select).
module dec3to8
  import demux1to8_deser_pkg::*;
(
  input  slot_t              i_idx,
  input  logic               i_en,
  output logic [N_SLOTS-1:0] o_onehot
);

  // Exactly one enable high when i_en is set, none otherwise.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to8_deser.sv
// Serial-to-parallel 1-to-8 TDM demultiplexer. Each valid bit lands in the slot
// named by an internal counter; the eighth bit completes a frame that is published
// through a valid/ready output register, with a sticky overflow for dropped frames.
module demux1to8_deser
  import demux1to8_deser_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_bit,
  input  logic               in_valid,
  input  logic               sync,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic [N_SLOTS-1:0] out_data,
  output logic               out_valid,
  output slot_t              slot_idx,
  output logic               overflow
);

  slot_t              r_slot;
  logic [N_SLOTS-1:0] r_shadow;
  logic [N_SLOTS-1:0] r_out_data;
  logic               r_out_valid;
  logic               r_overflow;

  slot_t              w_wr_idx;
  logic [N_SLOTS-1:0] w_we;
  logic [N_SLOTS-1:0] w_word;
  logic               w_complete;
  logic               w_accept;
  logic               w_load;
  logic               w_drop;
  logic               w_consume;

  // A sync cycle always targets slot 0 regardless of where the counter was.
  assign w_wr_idx = sync ? FIRST_SLOT : r_slot;

  dec3to8 u_dec (
    .i_idx    (w_wr_idx),
    .i_en     (in_valid),
    .o_onehot (w_we)
  );

  // The last bit bypasses the shadow so the word is ready on the same edge.
  assign w_word     = {in_bit, r_shadow[N_SLOTS-2:0]};
  assign w_complete = in_valid && !sync && (r_slot == LAST_SLOT);
  assign w_accept   = !r_out_valid || out_ready;
  assign w_load     = w_complete && w_accept;
  assign w_drop     = w_complete && !w_accept;
  assign w_consume  = r_out_valid && out_ready;

  // Slot counter: advance on each valid bit, restart on sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= FIRST_SLOT;
    end else if (in_valid) begin
      r_slot <= next_slot(w_wr_idx);
    end else if (sync) begin
      r_slot <= FIRST_SLOT;
    end
  end

  // Shadow register: write the arriving bit into its one-hot selected slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int k = 0; k < N_SLOTS; k++) begin
        if (w_we[k]) begin
          r_shadow[k] <= in_bit;
        end
      end
    end
  end

  // Output register: a completed frame loads (winning over a consume), else a consume empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_word;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overflow: a dropped frame sets it and outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign slot_idx  = r_slot;
  assign overflow  = r_overflow;

endmodule
